// File: rtl/uart_frame_parser.sv
// uart_frame_parser: frames bytes from an 8N1 receiver into checksum-verified register writes.
// Frame format: SYNC(0xA5) ADDR LEN payload[LEN*4] CHK, CHK = XOR of ADDR, LEN and payload.
// The payload is buffered and is only written out after the checksum matches.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
    parameter int unsigned MAX_WORDS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        wr_en_o,
    output logic [7:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    input  logic        wr_ready_i,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        busy_o
);

    localparam logic [7:0]  SyncByte = 8'hA5;
    localparam logic [7:0]  MaxLen   = 8'(MAX_WORDS);
    localparam int unsigned IdxW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned CntW     = $clog2(MAX_WORDS * 4 + 1);

    typedef enum logic [2:0] {StIdle, StAddr, StLen, StPayload, StChk, StDrain} state_e;

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]        word_idx_q, word_idx_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              buf_we;
    logic [31:0]       buf_q [MAX_WORDS];
    logic [9:0]        last_byte;
    logic              payload_last;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Index of the final payload byte of this frame.
    assign last_byte    = {len_q, 2'b00} - 10'd1;
    assign payload_last = (10'(byte_cnt_q) == last_byte);

    // Next-state, frame decode and pulse generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        chk_d       = chk_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        buf_we      = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                word_idx_d = '0;
                if (rx_valid_i && rx_data_i == SyncByte) state_d = StAddr;
            end
            StAddr: begin
                if (rx_valid_i) begin
                    addr_d  = rx_data_i;
                    chk_d   = rx_data_i;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (rx_valid_i) begin
                    len_d      = rx_data_i;
                    chk_d      = chk_q ^ rx_data_i;
                    byte_cnt_d = '0;
                    if (rx_data_i == 8'd0 || rx_data_i > MaxLen) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (rx_valid_i) begin
                    buf_we     = 1'b1;
                    chk_d      = chk_q ^ rx_data_i;
                    byte_cnt_d = byte_cnt_q + CntW'(1);
                    if (payload_last) state_d = StChk;
                end
            end
            StChk: begin
                if (rx_valid_i) begin
                    if (rx_data_i == chk_q) begin
                        frame_ok_d = 1'b1;
                        word_idx_d = '0;
                        state_d    = StDrain;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StDrain: begin
                // Bytes arriving while draining are dropped, not resynchronised on.
                overrun_d = rx_valid_i;
                if (wr_ready_i) begin
                    if (word_idx_q == len_q - 8'd1) state_d = StIdle;
                    else word_idx_d = word_idx_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        if (state_q inside {StAddr, StLen, StPayload, StChk} && !rx_valid_i) begin
            if (tmo_cnt_q == TmoLast) begin
                frame_err_d = 1'b1;
                state_d     = StIdle;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
        end
`endif
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // Payload buffer: little-endian byte lanes, contents only read out after a good CHK.
    always_ff @(posedge clock_i) begin
        if (buf_we) begin
            buf_q[IdxW'(byte_cnt_q >> 2)][8 * byte_cnt_q[1:0] +: 8] <= rx_data_i;
        end
    end

    // Write port and status outputs; write bus forced to zero outside DRAIN.
    always_comb begin
        wr_en_o     = (state_q == StDrain);
        wr_addr_o   = wr_en_o ? (addr_q + word_idx_q) : 8'h00;
        wr_data_o   = wr_en_o ? buf_q[IdxW'(word_idx_q)] : 32'h0;
        frame_ok_o  = frame_ok_q;
        frame_err_o = frame_err_q;
        overrun_o   = overrun_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus randomized frames
// compared against a byte-stream reference model of the frame format.
module tb_uart_frame_parser;

    localparam int MaxW = 8;
    localparam int TmoCycles = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        frame_ok;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Monitor state (only written by the monitor) and per-test baselines.
    int ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, hold_viol = 0;
    int ok_base, err_base, ovr_base, hold_base;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [39:0] got_w[$];

    // Stimulus frame bytes and model expectations.
    logic [7:0]  fr[$];
    logic [39:0] exp_w[$];
    int exp_ok, exp_err;

    uart_frame_parser #(.MAX_WORDS(MaxW), .TIMEOUT_CYCLES(TmoCycles)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .wr_ready_i (wr_ready),
        .frame_ok_o (frame_ok),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor sampling mid-cycle: transfers, pulses and stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (wr_en && wr_ready) got_w.push_back({wr_addr, wr_data});
            if (frame_ok) ok_cnt <= ok_cnt + 1;
            if (frame_err) err_cnt <= err_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (prev_stall && (!wr_en || wr_addr !== prev_addr || wr_data !== prev_data))
                hold_viol <= hold_viol + 1;
            prev_stall <= wr_en && !wr_ready;
            prev_addr  <= wr_addr;
            prev_data  <= wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ok_base = ok_cnt;
        err_base = err_cnt;
        ovr_base = ovr_cnt;
        hold_base = hold_viol;
        got_w.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_fr();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    // Append one frame with random payload; corrupt flips one checksum bit.
    task automatic build_frame(input logic [7:0] a, input logic [7:0] l, input bit corrupt);
        logic [7:0] s, b;
        s = a ^ l;
        fr.push_back(8'hA5);
        fr.push_back(a);
        fr.push_back(l);
        for (int k = 0; k < int'(l) * 4; k++) begin
            b = 8'($urandom);
            s ^= b;
            fr.push_back(b);
        end
        if (corrupt) s ^= 8'(1 << $urandom_range(0, 7));
        fr.push_back(s);
    endtask

    // Reference model: scan the byte stream by the frame rules, list expected writes.
    task automatic run_model();
        int i, n;
        logic [7:0] a, l, s;
        exp_ok = 0;
        exp_err = 0;
        exp_w.delete();
        i = 0;
        while (i < fr.size()) begin
            if (fr[i] != 8'hA5) begin
                i++;
            end else if (i + 2 >= fr.size()) begin
                i = fr.size();
            end else begin
                a = fr[i+1];
                l = fr[i+2];
                if (l == 0 || int'(l) > MaxW) begin
                    exp_err++;
                    i += 3;
                end else begin
                    n = int'(l) * 4;
                    if (i + 3 + n >= fr.size()) begin
                        i = fr.size();
                    end else begin
                        s = a ^ l;
                        for (int k = 0; k < n; k++) s ^= fr[i+3+k];
                        if (s == fr[i+3+n]) begin
                            exp_ok++;
                            for (int j = 0; j < int'(l); j++)
                                exp_w.push_back({a + 8'(j), fr[i+6+4*j], fr[i+5+4*j],
                                                 fr[i+4+4*j], fr[i+3+4*j]});
                        end else begin
                            exp_err++;
                        end
                        i += 4 + n;
                    end
                end
            end
        end
    endtask

    // Bounded wait for IDLE, optionally toggling wr_ready randomly.
    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while (busy && n < budget) begin
            if (rnd) wr_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        wr_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_ok, frame_err, overrun, busy} !== 44'h0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h ok=%b err=%b ovr=%b busy=%b, required all 0",
                     wr_en, wr_addr, wr_data, frame_ok, frame_err, overrun, busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single();
        clear_mon();
        wr_ready = 1'b1;
        fr = '{8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_fr();
        checks++;
        if ({frame_ok, wr_en, wr_addr, wr_data} !== {1'b1, 1'b1, 8'h10, 32'h44332211}) begin
            errors++;
            $display("FAIL single_first: ok=%b en=%b addr=%h data=%h, required 1 1 10 44332211",
                     frame_ok, wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if ({frame_ok, wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: ok=%b en=%b busy=%b, required 0 0 0", frame_ok, wr_en, busy);
        end
        checks++;
        if (got_w.size() != 1 || got_w[0] !== {8'h10, 32'h44332211}) begin
            errors++;
            $display("FAIL single_writes: got %0d writes first=%h, required 1 write 1044332211",
                     got_w.size(), got_w.size() > 0 ? got_w[0] : 40'h0);
        end
    endtask

    task automatic test_wrap_stall();
        clear_mon();
        wr_ready = 1'b0;
        fr = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00, 8'hFE};
        run_model();
        send_fr();
        repeat (5) begin
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'hFF, 32'h1}) begin
                errors++;
                $display("FAIL stall_hold: en=%b addr=%h data=%h, required 1 ff 00000001",
                         wr_en, wr_addr, wr_data);
            end
            step();
        end
        wr_ready = 1'b1;
        wait_idle(20, 1'b0);
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes, required %0d", got_w.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL wrap_write%0d: got %h, required %h", i, got_w[i], exp_w[i]);
                end
            end
        end
        checks++;
        if (hold_viol - hold_base != 0) begin
            errors++;
            $display("FAIL wrap_stable: %0d hold violations, required 0", hold_viol - hold_base);
        end
    endtask

    task automatic test_bad_chk();
        clear_mon();
        wr_ready = 1'b1;
        fr = '{8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54};
        send_fr();
        checks++;
        if ({frame_err, frame_ok, wr_en, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL badchk_pulse: err=%b ok=%b en=%b busy=%b, required 1 0 0 0",
                     frame_err, frame_ok, wr_en, busy);
        end
        step();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL badchk_width: err=%b one cycle later, required 0", frame_err);
        end
        fr.delete();
        build_frame(8'h20, 8'h03, 1'b0);
        run_model();
        send_fr();
        wait_idle(20, 1'b0);
        checks++;
        if (ok_cnt - ok_base != 1 || err_cnt - err_base != 1) begin
            errors++;
            $display("FAIL badchk_counts: ok=%0d err=%0d, required 1 1",
                     ok_cnt - ok_base, err_cnt - err_base);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL badchk_count: got %0d writes, required %0d", got_w.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL badchk_write%0d: got %h, required %h", i, got_w[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_bad_len();
        clear_mon();
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL badlen_busy: busy=%b after SYNC, required 1", busy);
        end
        send_byte(8'h10);
        send_byte(8'h00);
        checks++;
        if ({frame_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL badlen_zero: err=%b busy=%b, required 1 0", frame_err, busy);
        end
        fr = '{8'hA5, 8'h10, 8'h09};
        send_fr();
        checks++;
        if ({frame_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL badlen_big: err=%b busy=%b, required 1 0", frame_err, busy);
        end
        fr = '{8'h00, 8'hFF, 8'h5A};
        send_fr();
        step();
        checks++;
        if (err_cnt - err_base != 2 || ok_cnt - ok_base != 0 || busy !== 1'b0 || got_w.size() != 0) begin
            errors++;
            $display("FAIL badlen_garbage: err=%0d ok=%0d busy=%b writes=%0d, required 2 0 0 0",
                     err_cnt - err_base, ok_cnt - ok_base, busy, got_w.size());
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        wr_ready = 1'b0;
        fr.delete();
        build_frame(8'h30, 8'h02, 1'b0);
        run_model();
        send_fr();
        send_byte(8'h77);
        checks++;
        if ({overrun, busy, wr_en, wr_addr} !== {3'b111, 8'h30}) begin
            errors++;
            $display("FAIL overrun_pulse: ovr=%b busy=%b en=%b addr=%h, required 1 1 1 30",
                     overrun, busy, wr_en, wr_addr);
        end
        repeat (3) step();
        wr_ready = 1'b1;
        wait_idle(20, 1'b0);
        checks++;
        if (ovr_cnt - ovr_base != 1 || hold_viol - hold_base != 0) begin
            errors++;
            $display("FAIL overrun_counts: ovr=%0d holdviol=%0d, required 1 0",
                     ovr_cnt - ovr_base, hold_viol - hold_base);
        end
        checks++;
        if (got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL overrun_count: got %0d writes, required %0d", got_w.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL overrun_write%0d: got %h, required %h", i, got_w[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        wr_ready = 1'b1;
        fr = '{8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) send_byte(fr[i]);
`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int lat = 0;
            for (int i = 1; i <= 100 && lat == 0; i++) begin
                step();
                if (frame_err) lat = i;
            end
            checks++;
            if (lat < TmoCycles - 2 || lat > TmoCycles + 2) begin
                errors++;
                $display("FAIL timeout_latency: err after %0d cycles, required about %0d",
                         lat, TmoCycles);
            end
            checks++;
            if (busy !== 1'b0 || got_w.size() != 0) begin
                errors++;
                $display("FAIL timeout_idle: busy=%b writes=%0d, required 0 0", busy, got_w.size());
            end
        end
`else
        repeat (200) step();
        checks++;
        if (busy !== 1'b1 || err_cnt - err_base != 0) begin
            errors++;
            $display("FAIL notimeout_wait: busy=%b err=%0d, required 1 0", busy, err_cnt - err_base);
        end
        for (int i = 4; i < fr.size(); i++) send_byte(fr[i]);
        run_model();
        wait_idle(20, 1'b0);
        checks++;
        if (got_w.size() != exp_w.size() || (exp_w.size() > 0 && got_w[0] !== exp_w[0])) begin
            errors++;
            $display("FAIL notimeout_write: got %0d writes, required %0d", got_w.size(), exp_w.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        clear_mon();
        wr_ready = 1'b0;
        fr = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        send_fr();
        rst = 1'b1;
        step();
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_ok, frame_err, overrun, busy} !== 44'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: en=%b busy=%b ok=%b err=%b, required all 0",
                     wr_en, busy, frame_ok, frame_err);
        end
        rst = 1'b0;
        wr_ready = 1'b1;
        fr = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h9A};
        send_fr();
        repeat (4) step();
        checks++;
        if (got_w.size() != 0 || ok_cnt - ok_base != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_payload: writes=%0d ok=%0d busy=%b, required 0 0 0",
                     got_w.size(), ok_cnt - ok_base, busy);
        end
        wr_ready = 1'b0;
        fr.delete();
        build_frame(8'h40, 8'h02, 1'b0);
        send_fr();
        clear_mon();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_ready = 1'b1;
        repeat (5) step();
        checks++;
        if (got_w.size() != 0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drain: writes=%0d en=%b busy=%b, required 0 0 0",
                     got_w.size(), wr_en, busy);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int it = 0; it < 20; it++) begin
            clear_mon();
            fr.delete();
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g;
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                fr.push_back(g);
            end
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                fr.push_back(8'hA5);
                fr.push_back(8'($urandom));
                fr.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MaxW + 1, 255)));
            end else begin
                build_frame(8'($urandom), 8'($urandom_range(1, MaxW)), kind == 1);
            end
            run_model();
            wr_ready = 1'($urandom_range(0, 1));
            send_fr();
            wait_idle(400, 1'b1);
            step();
            checks++;
            if (ok_cnt - ok_base != exp_ok || err_cnt - err_base != exp_err
                || ovr_cnt - ovr_base != 0 || hold_viol - hold_base != 0) begin
                errors++;
                $display("FAIL rand%0d_status: ok=%0d err=%0d ovr=%0d hold=%0d, required %0d %0d 0 0",
                         it, ok_cnt - ok_base, err_cnt - err_base, ovr_cnt - ovr_base,
                         hold_viol - hold_base, exp_ok, exp_err);
            end
            checks++;
            if (got_w.size() != exp_w.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes, required %0d",
                         it, got_w.size(), exp_w.size());
            end else begin
                foreach (exp_w[i]) begin
                    checks++;
                    if (got_w[i] !== exp_w[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got %h, required %h",
                                 it, i, got_w[i], exp_w[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_stall();
        test_bad_chk();
        test_bad_len();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream framer sitting directly downstream of the 8N1 UART receiver. Consumes received bytes (`data`/`data_valid` of the receiver), recognises fixed-format command frames, buffers and checksum-checks the payload, and only on a good frame issues 32-bit register writes to the design's register bank over a valid/ready port. Malformed, truncated or corrupted frames produce no writes.

## Interface
- `MAX_WORDS`, 8, maximum payload length in 32-bit words (1..255).
- `TIMEOUT_CYCLES`, 100000, idle clocks between bytes inside a frame before abort.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid this cycle.
- `wr_en`  out  1  write request valid.
- `wr_addr`  out  8  word address.
- `wr_data`  out  32  write data.
- `wr_ready`  in  1  consumer accepts; transfer = `wr_en & wr_ready`.
- `frame_ok`  out  1  one-cycle pulse, good frame accepted.
- `frame_err`  out  1  one-cycle pulse, frame aborted.
- `overrun`  out  1  one-cycle pulse, byte dropped while draining.
- `busy`  out  1  state != IDLE.

## Operation
- Frame: SYNC (0xA5), ADDR, LEN (words), LEN×4 payload bytes, CHK.
- CHK = XOR of ADDR, LEN and all payload bytes (SYNC excluded).
- Payload little-endian per word: first byte → `wr_data[7:0]`.
- States: IDLE, ADDR, LEN, PAYLOAD, CHK, DRAIN.
- IDLE: byte 0xA5 → ADDR; any other byte silently ignored.
- ADDR: store base address, seed checksum → LEN.
- LEN: 1..MAX_WORDS → PAYLOAD; 0 or >MAX_WORDS → `frame_err`, IDLE.
- PAYLOAD: bytes written into a MAX_WORDS×32 buffer; after byte LEN×4 → CHK.
- CHK: match → `frame_ok`, DRAIN; mismatch → `frame_err`, IDLE, no writes.
- DRAIN: word i presented with `wr_addr` = ADDR+i mod 256 (8-bit wrap); advance on transfer; after word LEN-1 transfers → IDLE.
- `rx_valid` in DRAIN: byte dropped, `overrun` pulses, state unaffected (no resync until IDLE).
- Buffer holds only the current frame; no writes are ever issued for an unverified frame.

## Timing
- Reset: all outputs 0, state IDLE; reset mid-frame or mid-drain discards everything, no further writes.
- State change registered: byte at cycle t takes effect at t+1.
- `frame_ok`/`frame_err` asserted in cycle t+1 after the deciding byte at t.
- DRAIN entered at t+1 after CHK; `wr_en`=1 with word 0 in that same cycle.
- While `wr_en`=1 and `wr_ready`=0: `wr_addr`/`wr_data` held stable.
- Transfer at cycle c: next word presented at c+1 (back-to-back with `wr_ready` high, LEN cycles total); last transfer → `wr_en`=0, `busy`=0 at c+1.
- `busy` high from cycle after SYNC until IDLE re-entered.
- Checksum and counters use 8-bit wrap arithmetic; byte counter wide enough for MAX_WORDS×4.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined: counter cleared on every `rx_valid` in ADDR/LEN/PAYLOAD/CHK, incremented otherwise; reaching TIMEOUT_CYCLES → `frame_err` next cycle, IDLE, partial frame discarded. Not active in IDLE or DRAIN.
- Not defined: no timeout counter; parser waits indefinitely for the next byte. `TIMEOUT_CYCLES` unused.

## Test plan
- A5 10 01 11 22 33 44 55, `wr_ready`=1 → `frame_ok`, single write addr 0x10 data 0x44332211, then `busy`=0.
- A5 FF 02 01 00 00 00 02 00 00 00 FE, `wr_ready` low 5 cycles then high → `wr_en` held with (0xFF, 0x00000001) stable, then (0x00, 0x00000002); address wraps.
- First frame with CHK 0x54 → `frame_err` one cycle, `wr_en` never asserted; following good frame accepted normally.
- A5 10 00 → `frame_err` after LEN byte; A5 10 09 (MAX_WORDS=8) → `frame_err`; garbage bytes 00 FF 5A in IDLE → no pulses, `busy`=0.
- Good 2-word frame with `wr_ready`=0, extra byte 0x77 during DRAIN → `overrun` pulse, both writes still issued unchanged.
- With `UART_FRAME_TIMEOUT_EN`, TIMEOUT_CYCLES=50: A5 10 01 11 then silence → `frame_err` ~50 cycles after last byte, IDLE; reset asserted mid-PAYLOAD → outputs 0, no writes.
